// File: rtl/md_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : md_scheduler_if                                                 |
// | Brief    : Issue/result bundle between E stage, hazard unit and md_scheduler|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface md_scheduler_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : md_scheduler                                                    |
// | Brief    : Multi-cycle MULT/DIV sequencer holding the HI/LO registers.     |
// |            Optional MADD family enabled by macro MD_SCHEDULER_MADD_EN.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module md_scheduler #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    md_scheduler_if.slave  md_bus
);

    localparam int c_max_lat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_cnt_w   = $clog2(c_max_lat + 1);

    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mthi  = 4'd5;
    localparam logic [3:0] c_op_mtlo  = 4'd6;
`ifdef MD_SCHEDULER_MADD_EN
    localparam logic [3:0] c_op_madd  = 4'd7;
    localparam logic [3:0] c_op_maddu = 4'd8;
    localparam logic [3:0] c_op_msub  = 4'd9;
    localparam logic [3:0] c_op_msubu = 4'd10;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic [31:0]          r_tmp_hi;
    logic [31:0]          r_tmp_lo;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic                 r_done;

    logic [63:0]          w_prod_s;
    logic [63:0]          w_prod_u;
    logic [31:0]          w_a_mag;
    logic [31:0]          w_b_mag;
    logic [31:0]          w_q_mag;
    logic [31:0]          w_r_mag;
    logic [31:0]          w_sdiv_q;
    logic [31:0]          w_sdiv_r;
    logic [63:0]          w_result;
    logic                 w_is_md;
    logic [c_cnt_w-1:0]   w_lat_load;

    // Sign-extended 64x64 multiply: low 64 bits equal the signed 32x32 product.
    assign w_prod_s = {{32{md_bus.a[31]}}, md_bus.a} * {{32{md_bus.b[31]}}, md_bus.b};
    assign w_prod_u = {32'd0, md_bus.a} * {32'd0, md_bus.b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        w_a_mag  = md_bus.a[31] ? -md_bus.a : md_bus.a;
        w_b_mag  = md_bus.b[31] ? -md_bus.b : md_bus.b;
        w_q_mag  = w_a_mag / w_b_mag;
        w_r_mag  = w_a_mag % w_b_mag;
        w_sdiv_q = (md_bus.a[31] ^ md_bus.b[31]) ? -w_q_mag : w_q_mag;
        w_sdiv_r = md_bus.a[31] ? -w_r_mag : w_r_mag;
    end

    // A zero divisor leaves the current HI/LO as the value to commit.
    always_comb begin
        w_result   = {r_hi, r_lo};
        w_is_md    = 1'b0;
        w_lat_load = c_mult_load;
        case (md_bus.op)
            c_op_mult: begin
                w_is_md  = 1'b1;
                w_result = w_prod_s;
            end
            c_op_multu: begin
                w_is_md  = 1'b1;
                w_result = w_prod_u;
            end
            c_op_div: begin
                w_is_md    = 1'b1;
                w_lat_load = c_div_load;
                if (md_bus.b != 32'd0) begin
                    w_result = {w_sdiv_r, w_sdiv_q};
                end
            end
            c_op_divu: begin
                w_is_md    = 1'b1;
                w_lat_load = c_div_load;
                if (md_bus.b != 32'd0) begin
                    w_result = {md_bus.a % md_bus.b, md_bus.a / md_bus.b};
                end
            end
`ifdef MD_SCHEDULER_MADD_EN
            c_op_madd: begin
                w_is_md  = 1'b1;
                w_result = {r_hi, r_lo} + w_prod_s;
            end
            c_op_maddu: begin
                w_is_md  = 1'b1;
                w_result = {r_hi, r_lo} + w_prod_u;
            end
            c_op_msub: begin
                w_is_md  = 1'b1;
                w_result = {r_hi, r_lo} - w_prod_s;
            end
            c_op_msubu: begin
                w_is_md  = 1'b1;
                w_result = {r_hi, r_lo} - w_prod_u;
            end
`endif
            default: ;
        endcase
    end

    // Issue-cycle term lets a dependent mfhi/mflo in D stall without delay.
    assign md_bus.busy = (md_bus.start & w_is_md & (r_state == ST_IDLE)) | (r_state == ST_RUN);
    assign md_bus.done = r_done;
    assign md_bus.hi   = r_hi;
    assign md_bus.lo   = r_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (md_bus.start) begin
                        if (w_is_md) begin
                            {r_tmp_hi, r_tmp_lo} <= w_result;
                            r_count              <= w_lat_load;
                            r_state              <= ST_RUN;
                        end else if (md_bus.op == c_op_mthi) begin
                            r_hi <= md_bus.a;
                        end else if (md_bus.op == c_op_mtlo) begin
                            r_lo <= md_bus.a;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_count == c_cnt_one) begin
                        r_hi    <= r_tmp_hi;
                        r_lo    <= r_tmp_lo;
                        r_done  <= 1'b1;
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count - c_cnt_one;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_md_scheduler                                                 |
// | Brief    : Vector table, corner sequences and random ops vs. a HI/LO model  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_md_scheduler;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    typedef longint unsigned u64_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic clk;
    logic rst_n;
    md_scheduler_if md_bus ();

    md_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .md_bus (md_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int proto_events = 0;
    logic busy_last = 1'b0;
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;
    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue during an in-flight op (other than in the commit cycle) is a protocol violation.
    always @(negedge clk) begin
        #2;
        if (rst_n && md_bus.start && busy_last && !md_bus.done) proto_events++;
        busy_last = md_bus.busy;
    end

    // Reference HI/LO update straight from the arithmetic rules; returns Busy length.
    function automatic int model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] acc, ps, pu;
        int q, r, lat;
        lat = 0;
        ps  = 64'(longint'($signed(a)) * longint'($signed(b)));
        pu  = u64_t'(a) * u64_t'(b);
        acc = {ref_hi, ref_lo};
        case (op)
            4'd1: begin lat = MULT_LAT; acc = ps; end
            4'd2: begin lat = MULT_LAT; acc = pu; end
            4'd3: begin
                lat = DIV_LAT;
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        acc = {32'h0, 32'h8000_0000};
                    end else begin
                        q = int'(a) / int'(b);
                        r = int'(a) % int'(b);
                        acc = {r, q};
                    end
                end
            end
            4'd4: begin
                lat = DIV_LAT;
                if (b != 0) acc = {a % b, a / b};
            end
            4'd5: acc[63:32] = a;
            4'd6: acc[31:0]  = a;
`ifdef MD_SCHEDULER_MADD_EN
            4'd7:  begin lat = MULT_LAT; acc = acc + ps; end
            4'd8:  begin lat = MULT_LAT; acc = acc + pu; end
            4'd9:  begin lat = MULT_LAT; acc = acc - ps; end
            4'd10: begin lat = MULT_LAT; acc = acc - pu; end
`endif
            default: ;
        endcase
        {ref_hi, ref_lo} = acc;
        return lat;
    endfunction

    // Issue one op from idle, measure Busy length, then check Done and HI/LO.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eh, input logic [31:0] el,
                          input string tag);
        int n, g;
        @(negedge clk);
        md_bus.start = 1'b1;
        md_bus.op    = op;
        md_bus.a     = a;
        md_bus.b     = b;
        #1;
        chk({tag, "_issue_busy"}, 32'(md_bus.busy), 32'(lat > 0));
        @(posedge clk);
        #1;
        md_bus.start = 1'b0;
        md_bus.op    = 4'($urandom);
        md_bus.a     = $urandom;
        md_bus.b     = $urandom;
        n = (lat > 0) ? 1 : 0;
        g = 0;
        @(negedge clk);
        #1;
        while (md_bus.busy && g < 40) begin
            n++;
            g++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_busy_len"}, 32'(n), 32'(lat));
        chk({tag, "_done"}, 32'(md_bus.done), 32'(lat > 0));
        chk({tag, "_hi"}, md_bus.hi, eh);
        chk({tag, "_lo"}, md_bus.lo, el);
        @(negedge clk);
        #1;
        chk({tag, "_done_clr"}, 32'(md_bus.done), 32'd0);
    endtask

    initial begin
        logic [16:0] bv, dv;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        int          rlat;
        bit          saw_done;

        vecs[0]  = '{4'd5, 32'h1234_5678, 32'h0, 0, 32'h1234_5678, 32'h0000_0000};
        vecs[1]  = '{4'd6, 32'h0000_ABCD, 32'h0, 0, 32'h1234_5678, 32'h0000_ABCD};
        vecs[2]  = '{4'd1, 32'hFFFF_FFFE, 32'd3, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[3]  = '{4'd2, 32'hFFFF_FFFE, 32'd3, MULT_LAT, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[4]  = '{4'd3, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[5]  = '{4'd4, 32'd7, 32'd0, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000};
        vecs[7]  = '{4'd4, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14};
        vecs[8]  = '{4'd3, 32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'd1, 32'hFFFF_FFFD};
        vecs[9]  = '{4'd0, 32'hDEAD_BEEF, 32'h1, 0, 32'd1, 32'hFFFF_FFFD};
        vecs[10] = '{4'd15, 32'hDEAD_BEEF, 32'h1, 0, 32'd1, 32'hFFFF_FFFD};
        vecs[11] = '{4'd5, 32'h0, 32'h0, 0, 32'h0, 32'hFFFF_FFFD};
        vecs[12] = '{4'd6, 32'hFFFF_FFFF, 32'h0, 0, 32'h0, 32'hFFFF_FFFF};
`ifdef MD_SCHEDULER_MADD_EN
        vecs[13] = '{4'd8, 32'd1, 32'd1, MULT_LAT, 32'd1, 32'h0};
        vecs[14] = '{4'd9, 32'd1, 32'd1, MULT_LAT, 32'h0, 32'hFFFF_FFFF};
`else
        vecs[13] = '{4'd8, 32'd1, 32'd1, 0, 32'h0, 32'hFFFF_FFFF};
        vecs[14] = '{4'd9, 32'd1, 32'd1, 0, 32'h0, 32'hFFFF_FFFF};
`endif

        rst_n        = 1'b0;
        md_bus.start = 1'b0;
        md_bus.op    = 4'd0;
        md_bus.a     = 32'd0;
        md_bus.b     = 32'd0;
        #23;
        chk("rst_busy", 32'(md_bus.busy), 32'd0);
        chk("rst_done", 32'(md_bus.done), 32'd0);
        chk("rst_hi", md_bus.hi, 32'd0);
        chk("rst_lo", md_bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
                   vecs[i].exp_hi, vecs[i].exp_lo, $sformatf("vec%0d", i));
        end

        // MULT, MTLO and MULT injected while running, then DIV in the commit cycle.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            md_bus.start = 1'b0;
            md_bus.op    = 4'd0;
            case (i)
                0: begin md_bus.start = 1'b1; md_bus.op = 4'd1; md_bus.a = 32'd3; md_bus.b = 32'd4; end
                2: begin md_bus.start = 1'b1; md_bus.op = 4'd6; md_bus.a = 32'hDEAD_BEEF; end
                3: begin md_bus.start = 1'b1; md_bus.op = 4'd1; md_bus.a = 32'd2; md_bus.b = 32'd2; end
                5: begin md_bus.start = 1'b1; md_bus.op = 4'd3; md_bus.a = 32'd9; md_bus.b = 32'd2; end
                default: ;
            endcase
            #1;
            bv[i] = md_bus.busy;
            dv[i] = md_bus.done;
            if (i == 3) chk("seq_lo_in_run", md_bus.lo, 32'hFFFF_FFFF);
            if (i == 5) begin
                chk("seq_mult_hi", md_bus.hi, 32'd0);
                chk("seq_mult_lo", md_bus.lo, 32'd12);
            end
            if (i == 15) begin
                chk("seq_div_hi", md_bus.hi, 32'd1);
                chk("seq_div_lo", md_bus.lo, 32'd4);
            end
        end
        md_bus.start = 1'b0;
        chk("seq_busy_pattern", 32'(bv), 32'h0_7FFF);
        chk("seq_done_pattern", 32'(dv), 32'h0_8020);

        ref_hi = 32'd1;
        ref_lo = 32'd4;
        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            rlat = model(rop, ra, rb);
            run_op(rop, ra, rb, rlat, ref_hi, ref_lo, $sformatf("rnd%0d_op%0d", k, rop));
        end

        // Reset three cycles into a DIV: abandon with no commit.
        run_op(4'd5, 32'hA5A5_A5A5, 32'd0, 0, 32'hA5A5_A5A5, ref_lo, "pre_rst_mthi");
        @(negedge clk);
        md_bus.start = 1'b1;
        md_bus.op    = 4'd4;
        md_bus.a     = 32'd100;
        md_bus.b     = 32'd7;
        @(posedge clk);
        #1;
        md_bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(md_bus.busy), 32'd0);
        chk("midrst_hi", md_bus.hi, 32'd0);
        chk("midrst_lo", md_bus.lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            if (md_bus.done || md_bus.busy) saw_done = 1'b1;
        end
        chk("postrst_no_done", 32'(saw_done), 32'd0);
        chk("postrst_hi", md_bus.hi, 32'd0);
        chk("postrst_lo", md_bus.lo, 32'd0);

        chk("protocol_events", 32'(proto_events), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
